// File: rtl/spi_xfer_arbiter.sv
// Wishbone master that configures simple_spi and runs round-robin byte exchanges for NUM_REQ requesters.
// Optional macro SPI_XFER_IRQ_WAIT_EN: wait on inta_i instead of polling SPSR.RFEMPTY.
module spi_xfer_arbiter #(
    parameter int          NUM_REQ   = 2,
    parameter logic [7:0]  SPCR_INIT = 8'h50,
    parameter logic [7:0]  SPER_INIT = 8'h00
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   done_o,
    output logic [7:0]           rsp_data_o,
    output logic                 busy_o,
    output logic                 init_done_o,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [1:0]           adr_o,
    output logic [7:0]           dat_o,
    input  logic [7:0]           dat_i,
    input  logic                 ack_i,
    input  logic                 inta_i
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ADR_SPCR = 2'd0;
    localparam logic [1:0] ADR_SPSR = 2'd1;
    localparam logic [1:0] ADR_SPDR = 2'd2;
    localparam logic [1:0] ADR_SPER = 2'd3;

`ifdef SPI_XFER_IRQ_WAIT_EN
    localparam logic [7:0] SPCR_WR = SPCR_INIT | 8'h80;
    typedef enum logic [2:0] {
        CFG_SPCR, CFG_SPER, IDLE, WR_DATA, WAIT_IRQ, RD_DATA, CLR, DONE
    } state_t;
`else
    localparam logic [7:0] SPCR_WR = SPCR_INIT;
    typedef enum logic [2:0] {
        CFG_SPCR, CFG_SPER, IDLE, WR_DATA, POLL, RD_DATA, CLR, DONE
    } state_t;
    logic unused_inta;
    assign unused_inta = inta_i;
`endif

    state_t               state_q;
    logic [IDX_W-1:0]     ptr_q;
    logic [IDX_W-1:0]     win_q;
    logic [7:0]           tx_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [7:0]           rsp_q;
    logic                 busy_q;
    logic                 init_q;
    logic                 cyc_q;
    logic                 we_q;
    logic [1:0]           adr_q;
    logic [7:0]           dat_q;

    // Rotate requests so bit 0 is the pointer position; the lowest set bit then wins.
    logic [2*NUM_REQ-1:0] req_dbl;
    logic [NUM_REQ-1:0]   req_rot;
    logic [7:0]           tx_bytes [NUM_REQ];

    assign req_dbl = {req_i, req_i} >> ptr_q;
    assign req_rot = req_dbl[NUM_REQ-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_tx
            assign tx_bytes[gi] = req_data_i[8*gi +: 8];
        end
    endgenerate

    logic             grant_vld_d;
    logic [IDX_W-1:0] grant_idx_d;
    logic [IDX_W-1:0] ptr_d;

    always_comb begin
        int off;
        int sum;
        off = 0;
        sum = 0;
        grant_vld_d = |req_rot;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_rot[j]) begin
                off = j;
            end
        end
        sum = int'(ptr_q) + off;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        grant_idx_d = IDX_W'(sum);
        sum = sum + 1;
        if (sum >= NUM_REQ) begin
            sum = 0;
        end
        ptr_d = IDX_W'(sum);
    end

    // Access descriptor for whichever state currently owns the bus.
    logic       acc_en_d;
    logic       acc_we_d;
    logic [1:0] acc_adr_d;
    logic [7:0] acc_dat_d;

    always_comb begin
        acc_en_d  = 1'b1;
        acc_we_d  = 1'b1;
        acc_adr_d = ADR_SPCR;
        acc_dat_d = 8'h00;
        case (state_q)
            CFG_SPCR: begin acc_adr_d = ADR_SPCR; acc_dat_d = SPCR_WR;   end
            CFG_SPER: begin acc_adr_d = ADR_SPER; acc_dat_d = SPER_INIT; end
            WR_DATA:  begin acc_adr_d = ADR_SPDR; acc_dat_d = tx_q;      end
`ifndef SPI_XFER_IRQ_WAIT_EN
            POLL:     begin acc_we_d = 1'b0; acc_adr_d = ADR_SPSR;       end
`endif
            RD_DATA:  begin acc_we_d = 1'b0; acc_adr_d = ADR_SPDR;       end
            CLR:      begin acc_adr_d = ADR_SPSR; acc_dat_d = 8'h80;     end
            default:  acc_en_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= CFG_SPCR;
            ptr_q   <= '0;
            win_q   <= '0;
            tx_q    <= 8'h00;
            done_q  <= '0;
            rsp_q   <= 8'h00;
            busy_q  <= 1'b0;
            init_q  <= 1'b0;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= 2'd0;
            dat_q   <= 8'h00;
        end else begin
            done_q <= '0;
            if (acc_en_d) begin
                if (!cyc_q) begin
                    cyc_q <= 1'b1;
                    we_q  <= acc_we_d;
                    adr_q <= acc_adr_d;
                    dat_q <= acc_dat_d;
                end else if (ack_i) begin
                    // Dropping the cycle here guarantees an idle cycle before the next access.
                    cyc_q <= 1'b0;
                    we_q  <= 1'b0;
                    adr_q <= 2'd0;
                    dat_q <= 8'h00;
                    case (state_q)
                        CFG_SPCR: state_q <= CFG_SPER;
                        CFG_SPER: begin
                            state_q <= IDLE;
                            init_q  <= 1'b1;
                        end
`ifdef SPI_XFER_IRQ_WAIT_EN
                        WR_DATA:  state_q <= WAIT_IRQ;
`else
                        WR_DATA:  state_q <= POLL;
                        POLL: begin
                            if (!dat_i[0]) begin
                                state_q <= RD_DATA;
                            end
                        end
`endif
                        RD_DATA: begin
                            rsp_q   <= dat_i;
                            state_q <= CLR;
                        end
                        CLR: begin
                            done_q  <= NUM_REQ'(1) << win_q;
                            busy_q  <= 1'b0;
                            state_q <= DONE;
                        end
                        default: state_q <= state_q;
                    endcase
                end
            end else begin
                case (state_q)
                    IDLE: begin
                        if (grant_vld_d) begin
                            win_q   <= grant_idx_d;
                            tx_q    <= tx_bytes[grant_idx_d];
                            ptr_q   <= ptr_d;
                            busy_q  <= 1'b1;
                            state_q <= WR_DATA;
                        end
                    end
`ifdef SPI_XFER_IRQ_WAIT_EN
                    WAIT_IRQ: begin
                        if (inta_i) begin
                            state_q <= RD_DATA;
                        end
                    end
`endif
                    DONE:    state_q <= IDLE;
                    default: state_q <= state_q;
                endcase
            end
        end
    end

    assign done_o      = done_q;
    assign rsp_data_o  = rsp_q;
    assign busy_o      = busy_q;
    assign init_done_o = init_q;
    assign cyc_o       = cyc_q;
    assign stb_o       = cyc_q;
    assign we_o        = we_q;
    assign adr_o       = adr_q;
    assign dat_o       = dat_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Randomized bench for spi_xfer_arbiter: behavioural simple_spi slave plus round-robin reference model.
module tb_spi_xfer_arbiter;
    localparam int NR = 2;
`ifdef SPI_XFER_IRQ_WAIT_EN
    localparam logic [7:0] EXP_SPCR = 8'hD0;
`else
    localparam logic [7:0] EXP_SPCR = 8'h50;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*8-1:0] req_data;
    logic [NR-1:0]   done_o;
    logic [7:0]      rsp_data_o;
    logic            busy_o, init_done_o, cyc_o, stb_o, we_o;
    logic [1:0]      adr_o;
    logic [7:0]      dat_o;
    logic [7:0]      dat_i;
    logic            ack;
    logic            inta;

    always #5 clk = ~clk;

    spi_xfer_arbiter #(.NUM_REQ(NR), .SPCR_INIT(8'h50), .SPER_INIT(8'h00)) dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .req_data_i(req_data),
        .done_o(done_o), .rsp_data_o(rsp_data_o), .busy_o(busy_o), .init_done_o(init_done_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .dat_i(dat_i), .ack_i(ack), .inta_i(inta)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural simple_spi slave: random ack latency, random shift time, logs every access.
    logic [7:0]  spcr_r, sper_r, rx_byte, rx_next, rx_ovr;
    logic        rx_ovr_en;
    logic        rfempty, spif;
    int          shift_cnt, wait_cnt, proto_err;
    logic        p_cyc, p_ack, p_we;
    logic [1:0]  p_adr;
    logic [7:0]  p_dat;
    logic [10:0] ops[$];
    logic [7:0]  rx_q[$];

    assign inta = spif & spcr_r[7];

    always @(posedge clk) begin
        if (rst) begin
            ack <= 1'b0; dat_i <= 8'h00; rfempty <= 1'b1; spif <= 1'b0;
            shift_cnt <= 0; wait_cnt <= 0; spcr_r <= 8'h00; sper_r <= 8'h00;
            p_cyc <= 1'b0; p_ack <= 1'b0;
        end else begin
            if (p_cyc && !p_ack && (!cyc_o || {we_o, adr_o, dat_o} != {p_we, p_adr, p_dat}))
                proto_err <= proto_err + 1;
            if ((p_cyc && p_ack && cyc_o) || (stb_o != cyc_o))
                proto_err <= proto_err + 1;
            p_cyc <= cyc_o; p_ack <= ack; p_we <= we_o; p_adr <= adr_o; p_dat <= dat_o;
            if (shift_cnt > 0) begin
                shift_cnt <= shift_cnt - 1;
                if (shift_cnt == 1) begin rfempty <= 1'b0; spif <= 1'b1; end
            end
            ack <= 1'b0;
            if (cyc_o && !ack) begin
                if (wait_cnt > 0) begin
                    wait_cnt <= wait_cnt - 1;
                end else begin
                    ack <= 1'b1;
                    wait_cnt <= $urandom_range(0, 2);
                    if (we_o) begin
                        ops.push_back({1'b1, adr_o, dat_o});
                        case (adr_o)
                            2'd0: spcr_r <= dat_o;
                            2'd3: sper_r <= dat_o;
                            2'd2: begin
                                rx_byte   <= rx_ovr_en ? rx_ovr : rx_next;
                                rx_q.push_back(rx_ovr_en ? rx_ovr : rx_next);
                                rx_next   <= 8'($urandom);
                                shift_cnt <= $urandom_range(1, 8);
                            end
                            default: if (dat_o[7]) spif <= 1'b0;
                        endcase
                    end else if (adr_o == 2'd1) begin
                        dat_i <= {spif, 6'b0, rfempty};
                        ops.push_back({1'b0, 2'd1, spif, 6'b0, rfempty});
                    end else begin
                        dat_i   <= rx_byte;
                        rfempty <= 1'b1;
                        ops.push_back({1'b0, adr_o, rx_byte});
                    end
                end
            end
        end
    end

    // Reference arbitration: first requester at or after the pointer, wrapping.
    int mdl_ptr;
    function automatic int mdl_pick(input logic [NR-1:0] rv);
        for (int k = 0; k < NR; k++) begin
            if (rv[(mdl_ptr + k) % NR]) return (mdl_ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic wait_done(input int maxc, output bit got, output logic [NR-1:0] d,
                             output logic [7:0] r);
        got = 1'b0; d = '0; r = 8'h00;
        for (int c = 0; c < maxc && !got; c++) begin
            @(negedge clk);
            if (done_o != '0) begin got = 1'b1; d = done_o; r = rsp_data_o; end
        end
    endtask

    // Pops one transfer's worth of logged accesses and reports whether it had the right shape.
    task automatic grab_xfer(output bit ok, output logic [7:0] w2, output logic [7:0] r2,
                             output int npoll);
        logic [10:0] op;
        ok = 1'b1; w2 = 8'h00; r2 = 8'h00; npoll = 0;
        if (ops.size() < 3) begin ok = 1'b0; return; end
        op = ops.pop_front();
        if (op[10:8] != 3'b110) ok = 1'b0;
        w2 = op[7:0];
        while (ops.size() > 0 && ops[0][10:8] == 3'b001) begin
            op = ops.pop_front();
            npoll++;
            if (ops.size() > 0 && ops[0][10:8] == 3'b001 && !op[0]) ok = 1'b0;
            if (!(ops.size() > 0 && ops[0][10:8] == 3'b001) && op[0]) ok = 1'b0;
        end
`ifdef SPI_XFER_IRQ_WAIT_EN
        if (npoll != 0) ok = 1'b0;
`else
        if (npoll < 1) ok = 1'b0;
`endif
        if (ops.size() < 2) begin ok = 1'b0; return; end
        op = ops.pop_front();
        if (op[10:8] != 3'b010) ok = 1'b0;
        r2 = op[7:0];
        op = ops.pop_front();
        if (op != {1'b1, 2'd1, 8'h80}) ok = 1'b0;
    endtask

    task automatic test_reset();
        bit got;
        rst = 1'b1; req = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++;
        if ({cyc_o, stb_o, we_o, adr_o, dat_o, done_o, busy_o, init_done_o, rsp_data_o} !== '0) begin
            bad++; $display("FAIL reset_outputs: got cyc=%b busy=%b init=%b done=%b rsp=%h required all 0",
                            cyc_o, busy_o, init_done_o, done_o, rsp_data_o);
        end
        ops.delete(); rx_q.delete(); mdl_ptr = 0;
        rst = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin @(negedge clk); got = init_done_o; end
        total++;
        if (!got) begin bad++; $display("FAIL init_done: got 0 required 1 within 60 cycles"); end
        total++;
        if (ops.size() != 2) begin
            bad++; $display("FAIL cfg_count: got %0d accesses required 2", ops.size());
        end else if (ops[0] !== {1'b1, 2'd0, EXP_SPCR} || ops[1] !== {1'b1, 2'd3, 8'h00}) begin
            bad++; $display("FAIL cfg_writes: got %h %h required %h %h",
                            ops[0], ops[1], {1'b1, 2'd0, EXP_SPCR}, {1'b1, 2'd3, 8'h00});
        end
        repeat (10) @(negedge clk);
        total++;
        if (ops.size() != 2 || cyc_o !== 1'b0 || init_done_o !== 1'b1) begin
            bad++; $display("FAIL idle_quiet: got accesses=%0d cyc=%b init=%b required 2 0 1",
                            ops.size(), cyc_o, init_done_o);
        end
        $display("test_reset: cfg accesses=%0d init_done=%b", ops.size(), init_done_o);
        ops.delete();
    endtask

    task automatic test_single();
        bit got, ok;
        logic [NR-1:0] d;
        logic [7:0] r, w2, r2;
        int np, exp;
        rx_ovr_en = 1'b1; rx_ovr = 8'h3C;
        req_data[7:0] = 8'hA5;
        req = 2'b01;
        exp = mdl_pick(req);
        wait_done(400, got, d, r);
        req = 2'b00;
        mdl_ptr = (exp + 1) % NR;
        total++;
        if (!got) begin bad++; $display("FAIL single_timeout: no done_o within 400 cycles"); end
        total++;
        if (d !== 2'b01 || r !== 8'h3C) begin
            bad++; $display("FAIL single_done: got done=%b rsp=%h required 01 3c", d, r);
        end
        grab_xfer(ok, w2, r2, np);
        void'(rx_q.pop_front());
        total++;
        if (!ok || w2 !== 8'hA5 || r2 !== 8'h3C) begin
            bad++; $display("FAIL single_bus: got shape_ok=%b w2=%h r2=%h required 1 a5 3c", ok, w2, r2);
        end
        @(negedge clk);
        total++;
        if (done_o !== '0 || busy_o !== 1'b0 || rsp_data_o !== 8'h3C) begin
            bad++; $display("FAIL single_after: got done=%b busy=%b rsp=%h required 00 0 3c",
                            done_o, busy_o, rsp_data_o);
        end
        rx_ovr_en = 1'b0;
        $display("test_single: done=%b rsp=%h polls=%0d", d, r, np);
    endtask

    // One served transfer: checks winner, response byte and the bus sequence against the models.
    task automatic serve_one(input string tag, output int winner);
        bit got, ok;
        logic [NR-1:0] d;
        logic [7:0] r, w2, r2, exp_rx, exp_tx;
        int np, exp;
        exp = mdl_pick(req);
        exp_tx = req_data[8*exp +: 8];
        wait_done(600, got, d, r);
        winner = exp;
        mdl_ptr = (exp + 1) % NR;
        exp_rx = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
        grab_xfer(ok, w2, r2, np);
        total++;
        if (!got) begin bad++; $display("FAIL %s_timeout: no done_o within 600 cycles", tag); end
        total++;
        if (d !== (NR'(1) << exp) || r !== exp_rx) begin
            bad++; $display("FAIL %s_done: got done=%b rsp=%h required %b %h", tag, d, r, NR'(1) << exp, exp_rx);
        end
        total++;
        if (!ok || w2 !== exp_tx || r2 !== exp_rx) begin
            bad++; $display("FAIL %s_bus: got shape_ok=%b w2=%h r2=%h required 1 %h %h",
                            tag, ok, w2, r2, exp_tx, exp_rx);
        end
        $display("%s: winner=%0d done=%b tx=%h rsp=%h polls=%0d", tag, exp, d, w2, r, np);
    endtask

    task automatic test_both();
        int w;
        req_data = NR*8'($urandom);
        req = 2'b11;
        for (int i = 0; i < 2; i++) begin
            serve_one("test_both", w);
            req[w] = 1'b0;
        end
        req = 2'b11;
        serve_one("test_both_fresh", w);
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_starve();
        int w;
        req = 2'b11;
        for (int i = 0; i < 5; i++) begin
            req_data = NR*8'($urandom);
            serve_one("test_starve", w);
            req[0] = (w != 0);
        end
        req = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_random();
        int w;
        for (int i = 0; i < 16; i++) begin
            req_data = NR*8'($urandom);
            req = NR'($urandom_range(1, (1 << NR) - 1));
            serve_one("test_random", w);
        end
        req = 2'b00;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid();
        bit found, got, ok;
        logic [NR-1:0] d;
        logic [7:0] r, w2, r2, exp_rx;
        int np;
        req_data[15:8] = 8'($urandom);
        req = 2'b10;
        found = 1'b0;
        for (int c = 0; c < 200 && !found; c++) begin
            @(negedge clk);
`ifdef SPI_XFER_IRQ_WAIT_EN
            found = cyc_o && we_o && adr_o == 2'd2;
`else
            found = cyc_o && !we_o && adr_o == 2'd1;
`endif
        end
        total++;
        if (!found) begin bad++; $display("FAIL midrst_reach: transfer access not seen within 200 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({cyc_o, stb_o, done_o, busy_o, init_done_o} !== '0) begin
            bad++; $display("FAIL midrst_outputs: got cyc=%b done=%b busy=%b init=%b required all 0",
                            cyc_o, done_o, busy_o, init_done_o);
        end
        ops.delete(); rx_q.delete(); mdl_ptr = 0;
        rst = 1'b0;
        wait_done(600, got, d, r);
        exp_rx = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
        total++;
        if (!got || d !== 2'b10 || r !== exp_rx) begin
            bad++; $display("FAIL midrst_done: got seen=%b done=%b rsp=%h required 1 10 %h", got, d, r, exp_rx);
        end
        total++;
        if (ops.size() < 2 || ops[0] !== {1'b1, 2'd0, EXP_SPCR} || ops[1] !== {1'b1, 2'd3, 8'h00}) begin
            bad++; $display("FAIL midrst_cfg: got %0d accesses, reconfiguration writes missing", ops.size());
        end else begin
            void'(ops.pop_front()); void'(ops.pop_front());
        end
        grab_xfer(ok, w2, r2, np);
        total++;
        if (!ok || w2 !== req_data[15:8]) begin
            bad++; $display("FAIL midrst_bus: got shape_ok=%b w2=%h required 1 %h", ok, w2, req_data[15:8]);
        end
        req = 2'b00;
        mdl_ptr = 0;
        rx_q.delete();
        $display("test_reset_mid: done=%b rsp=%h", d, r);
    endtask

    task automatic test_protocol();
        total++;
        if (proto_err != 0) begin
            bad++; $display("FAIL protocol: got %0d wishbone violations required 0", proto_err);
        end
        $display("test_protocol: violations=%0d", proto_err);
    endtask

    initial begin
        rst = 1'b1; req = '0; req_data = '0;
        rx_ovr_en = 1'b0; rx_ovr = 8'h00; rx_next = 8'($urandom);
        proto_err = 0; mdl_ptr = 0;
        test_reset();
        test_single();
        test_both();
        test_starve();
        test_random();
        test_reset_mid();
        test_protocol();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/spi_xfer_arbiter.md
Name: spi_xfer_arbiter

Overview:
Wishbone master that configures and sequences the simple_spi core on behalf of NUM_REQ byte-transfer requesters.
- After reset it programs SPCR/SPER.
- It then serves one byte exchange at a time under round-robin arbitration: write SPDR, wait for the receive byte, read SPDR, clear SPIF.
- Sits between client logic and the SPI core's Wishbone slave port, in the same domain as the core.

Parameters:
NUM_REQ, 2, number of requesters (1..8)
SPCR_INIT, 8'h50, SPCR value written at init (SPE=1, MSTR=1, mode 0, SPR=0)
SPER_INIT, 8'h00, SPER value written at init

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
req_i  in  NUM_REQ  per-requester transfer request, level
req_data_i  in  NUM_REQ*8  TX byte; requester k uses bits [8k+7:8k]
done_o  out  NUM_REQ  one-cycle completion pulse to served requester
rsp_data_o  out  8  RX byte, valid when any done_o bit is high
busy_o  out  1  high from grant until done pulse
init_done_o  out  1  high once configuration writes complete
cyc_o  out  1  Wishbone cycle
stb_o  out  1  Wishbone strobe
we_o  out  1  Wishbone write enable
adr_o  out  2  register address: 0 SPCR, 1 SPSR, 2 SPDR, 3 SPER
dat_o  out  8  Wishbone write data
dat_i  in  8  Wishbone read data
ack_i  in  1  Wishbone acknowledge
inta_i  in  1  SPI core interrupt (used only with the optional feature)

Behaviour:
- Reset, synchronous active-high on clk_i: all outputs 0, state CFG_SPCR, round-robin pointer 0, rsp_data_o 8'h00.
- Reset mid-operation aborts any Wishbone access and transfer. No done_o is issued. Configuration is rerun.
- Wishbone access rule:
  - cyc_o, stb_o, we_o, adr_o and dat_o are driven together and held until the cycle ack_i=1 is seen.
  - cyc_o/stb_o drop in the cycle after ack, giving at least one idle cycle between accesses.
  - Reads capture dat_i on the ack cycle.
  - ack_i with cyc_o low is ignored.
- States:
  - CFG_SPCR: write SPCR_INIT to adr 0 -> CFG_SPER.
  - CFG_SPER: write SPER_INIT to adr 3 -> IDLE. init_done_o goes 1 on the cycle after this ack and stays 1.
  - IDLE: if any req_i is high, pick the winner, latch its index and TX byte, busy_o=1 -> WR_DATA.
    - Winner is the first set bit at or after the pointer, wrapping from NUM_REQ-1 to 0.
    - The pointer moves to winner+1 (mod NUM_REQ) on grant.
  - WR_DATA: write the latched byte to adr 2 -> POLL.
  - POLL: read adr 1. If dat_i[0] (RFEMPTY) is 0 -> RD_DATA, else reissue the read after the mandatory idle cycle.
  - RD_DATA: read adr 2 into rsp_data_o -> CLR.
  - CLR: write 8'h80 to adr 1 (clear SPIF) -> DONE.
  - DONE: done_o[winner]=1 for exactly one cycle, busy_o=0 -> IDLE.
- Requesters hold req_i and data stable until their done_o pulse and drop req_i in the following cycle.
  - A req_i still high in the cycle after done is treated as a new request, subject to round-robin fairness.
- Latency, request to done with a 1-cycle-ack slave and no poll retry: 12 cycles plus SPI shift time.
- Requests arriving during CFG states wait. Requests deasserted before grant are simply not served.
- rsp_data_o holds its last value until the next RD_DATA ack.

Optional Feature:
SPI_XFER_IRQ_WAIT_EN
- Defined:
  - POLL is replaced by WAIT_IRQ, which issues no Wishbone traffic and waits for inta_i=1, then -> RD_DATA.
  - SPIE (bit 7) is forced to 1 in the SPCR init write.
  - The CLR write deasserts the interrupt.
- Undefined: inta_i is ignored and status polling is used as above.

Test Plan:
- Reset 3 cycles, no requests -> write adr0 8'h50, then write adr3 8'h00; init_done_o=1; no further bus activity.
- req_i=2'b01, data 8'hA5, SPI model returns 8'h3C -> bus sequence W2=A5, R1 until RFEMPTY=0, R2, W1=80; done_o=2'b01 for one cycle with rsp_data_o=8'h3C.
- req_i=2'b11 held, each requester dropping its request after its own done -> requester 0 served first, then 1. Pointer check: a fresh 2'b11 afterwards serves requester 0 again.
- Requester 1 holds req_i continuously while requester 0 pulses -> grants alternate 1,0,1; no starvation.
- rst_i asserted during POLL -> outputs zero next cycle, no done_o, configuration writes repeat, a pending request is then served normally.
- With SPI_XFER_IRQ_WAIT_EN: SPCR written 8'hD0; no SPSR reads before inta_i rises; done follows RD_DATA/CLR.
